axi_decerr_slave: RTL

//   Default responder on the slave side of the crossbar. Receives every AXI4 transaction whose

---
 rtl/axi_decerr_slave.sv | 135 +++++++++++++
 1 files changed

// File: rtl/axi_decerr_slave.sv
// Default AXI4 responder for unmapped addresses: drains writes and answers reads with RESP.
// Write and read channels are served by two independent FSMs; outputs depend on registered state only.
//
// state   | meaning
// W_IDLE  | waiting for AW (aw_ready=1)
// W_DATA  | draining W beats until w_last (w_ready=1)
// W_RESP  | presenting B until b_ready (b_valid=1)
// R_IDLE  | waiting for AR (ar_ready=1)
// R_DATA  | returning len+1 R beats (r_valid=1)
module axi_decerr_slave #(
   parameter int unsigned ID_WIDTH   = 4,
   parameter int unsigned DATA_WIDTH = 64,
   parameter logic [1:0]  RESP       = 2'b11,
   parameter logic [63:0] RDATA      = 64'hBADCAB1E
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [ID_WIDTH-1:0]   aw_id_i,
   input  logic                  aw_valid_i,
   output logic                  aw_ready_o,
   input  logic                  w_last_i,
   input  logic                  w_valid_i,
   output logic                  w_ready_o,
   output logic [ID_WIDTH-1:0]   b_id_o,
   output logic [1:0]            b_resp_o,
   output logic                  b_valid_o,
   input  logic                  b_ready_i,
   input  logic [ID_WIDTH-1:0]   ar_id_i,
   input  logic [7:0]            ar_len_i,
   input  logic                  ar_valid_i,
   output logic                  ar_ready_o,
   output logic [ID_WIDTH-1:0]   r_id_o,
   output logic [DATA_WIDTH-1:0] r_data_o,
   output logic [1:0]            r_resp_o,
   output logic                  r_last_o,
   output logic                  r_valid_o,
   input  logic                  r_ready_i
);

   localparam logic [DATA_WIDTH-1:0] RDATA_W = DATA_WIDTH'(RDATA);

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
   typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

   w_state_e            w_state_q, w_state_d;
   r_state_e            r_state_q, r_state_d;
   logic [ID_WIDTH-1:0] aw_id_q, aw_id_d;
   logic [ID_WIDTH-1:0] ar_id_q, ar_id_d;
   logic [7:0]          len_q, len_d;
   logic [7:0]          cnt_q, cnt_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         w_state_q <= W_IDLE;
         r_state_q <= R_IDLE;
         aw_id_q   <= '0;
         ar_id_q   <= '0;
         len_q     <= '0;
         cnt_q     <= '0;
      end else begin
         w_state_q <= w_state_d;
         r_state_q <= r_state_d;
         aw_id_q   <= aw_id_d;
         ar_id_q   <= ar_id_d;
         len_q     <= len_d;
         cnt_q     <= cnt_d;
      end
   end

   always_comb begin
      w_state_d  = w_state_q;
      aw_id_d    = aw_id_q;
      aw_ready_o = 1'b0;
      w_ready_o  = 1'b0;
      b_valid_o  = 1'b0;
      case (w_state_q)
         W_IDLE: begin
            aw_ready_o = 1'b1;
            if (aw_valid_i) begin
               aw_id_d   = aw_id_i;
               w_state_d = W_DATA;
            end
         end
         W_DATA: begin
            // burst length comes from w_last alone; AW len is not ported
            w_ready_o = 1'b1;
            if (w_valid_i && w_last_i) w_state_d = W_RESP;
         end
         W_RESP: begin
            b_valid_o = 1'b1;
            if (b_ready_i) w_state_d = W_IDLE;
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   assign b_id_o   = aw_id_q;
   assign b_resp_o = RESP;

   always_comb begin
      r_state_d  = r_state_q;
      ar_id_d    = ar_id_q;
      len_d      = len_q;
      cnt_d      = cnt_q;
      ar_ready_o = 1'b0;
      r_valid_o  = 1'b0;
      r_last_o   = 1'b0;
      case (r_state_q)
         R_IDLE: begin
            ar_ready_o = 1'b1;
            if (ar_valid_i) begin
               ar_id_d   = ar_id_i;
               len_d     = ar_len_i;
               cnt_d     = '0;
               r_state_d = R_DATA;
            end
         end
         R_DATA: begin
            r_valid_o = 1'b1;
            r_last_o  = (cnt_q == len_q);
            // the final beat leaves cnt at len, so len=255 never wraps
            if (r_ready_i) begin
               if (cnt_q == len_q) r_state_d = R_IDLE;
               else                cnt_d     = cnt_q + 8'd1;
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   assign r_id_o   = ar_id_q;
   assign r_data_o = RDATA_W;
   assign r_resp_o = RESP;

endmodule
